// File: rtl/cache_refill_ctrl.sv
// Miss/refill controller for a fully-associative tag CAM: writeback of dirty victim, line refill, tag commit.
// Optional performance counters (MissCount, WbCount) are enabled by defining REFILL_PERF_EN.
module cache_refill_ctrl #(
  parameter int LINE_WORDS = 4,
  parameter int WORD_W     = 2
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Req,
  input  logic [31:0]       Addr,
  input  logic              h,
  input  logic [29-WORD_W:0] Replaced_Tag,
  input  logic              Dirty,
  output logic [7:0]        RepPtr,
  output logic              TagValid,
  output logic              Stall,
  output logic              MemReq,
  output logic              MemWE,
  output logic [31:0]       MemAddr,
  input  logic              MemAck,
  output logic [WORD_W-1:0] WordIdx,
  output logic              FillWE,
`ifdef REFILL_PERF_EN
  output logic [31:0]       MissCount,
  output logic [31:0]       WbCount,
`endif
  output logic              LineDone
);

  localparam int TAG_W = 30 - WORD_W;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, WB, FILL, COMMIT} state_t;

  state_t             state_reg, state_next;
  logic [7:0]         rep_ptr_reg, rep_ptr_next;
  logic [WORD_W-1:0]  word_idx_reg, word_idx_next;
  logic [TAG_W-1:0]   miss_tag_reg, miss_tag_next;
  logic [TAG_W-1:0]   vic_tag_reg, vic_tag_next;
  logic               miss_detect;
  logic               wb_done;

  // Byte-offset bits never reach the controller's tag or word paths.
  logic addr_unused;
  assign addr_unused = ^Addr[WORD_W+1:0];

  assign miss_detect = (state_reg == IDLE) && Req && !h;
  assign wb_done     = (state_reg == WB) && MemAck && (word_idx_reg == LAST_WORD);

  assign Stall   = (state_reg != IDLE) || (Req && !h);
  assign RepPtr  = rep_ptr_reg;
  assign WordIdx = word_idx_reg;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_reg    <= IDLE;
      rep_ptr_reg  <= '0;
      word_idx_reg <= '0;
      miss_tag_reg <= '0;
      vic_tag_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      rep_ptr_reg  <= rep_ptr_next;
      word_idx_reg <= word_idx_next;
      miss_tag_reg <= miss_tag_next;
      vic_tag_reg  <= vic_tag_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    rep_ptr_next  = rep_ptr_reg;
    word_idx_next = word_idx_reg;
    miss_tag_next = miss_tag_reg;
    vic_tag_next  = vic_tag_reg;
    MemReq        = 1'b0;
    MemWE         = 1'b0;
    MemAddr       = '0;
    FillWE        = 1'b0;
    TagValid      = 1'b0;
    LineDone      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (miss_detect) begin
          miss_tag_next = Addr[31:WORD_W+2];
          vic_tag_next  = Replaced_Tag;
          word_idx_next = '0;
          state_next    = Dirty ? WB : FILL;
        end
      end
      WB: begin
        MemReq  = 1'b1;
        MemWE   = 1'b1;
        MemAddr = {vic_tag_reg, word_idx_reg, 2'b00};
        if (MemAck) begin
          word_idx_next = word_idx_reg + 1'b1;
          if (word_idx_reg == LAST_WORD) begin
            word_idx_next = '0;
            state_next    = FILL;
          end
        end
      end
      FILL: begin
        MemReq  = 1'b1;
        MemAddr = {miss_tag_reg, word_idx_reg, 2'b00};
        FillWE  = MemAck;
        if (MemAck) begin
          word_idx_next = word_idx_reg + 1'b1;
          if (word_idx_reg == LAST_WORD) begin
            word_idx_next = '0;
            state_next    = COMMIT;
          end
        end
      end
      COMMIT: begin
        // Tag write and dirty-clear both land on the current victim, then FIFO advances.
        TagValid     = 1'b1;
        LineDone     = 1'b1;
        rep_ptr_next = rep_ptr_reg + 8'd1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef REFILL_PERF_EN
  logic [1:0]  perf_evt;
  logic [31:0] perf_cnt [2];

  assign perf_evt = {wb_done, miss_detect};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_perf
      logic [31:0] cnt_reg;
      always_ff @(posedge CLK) begin
        if (Reset) begin
          cnt_reg <= '0;
        end else if (perf_evt[gi] && (cnt_reg != 32'hFFFF_FFFF)) begin
          cnt_reg <= cnt_reg + 32'd1;
        end
      end
      assign perf_cnt[gi] = cnt_reg;
    end
  endgenerate

  assign MissCount = perf_cnt[0];
  assign WbCount   = perf_cnt[1];
`else
  logic wb_done_unused;
  assign wb_done_unused = wb_done;
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: vector table for basic misses plus hand-written multi-cycle sequences.
module tb_cache_refill_ctrl;

  logic        CLK;
  logic        Reset;
  logic        Req;
  logic [31:0] Addr;
  logic        h;
  logic [27:0] Replaced_Tag;
  logic        Dirty;
  logic [7:0]  RepPtr;
  logic        TagValid;
  logic        Stall;
  logic        MemReq;
  logic        MemWE;
  logic [31:0] MemAddr;
  logic        MemAck;
  logic [1:0]  WordIdx;
  logic        FillWE;
  logic        LineDone;
`ifdef REFILL_PERF_EN
  logic [31:0] MissCount;
  logic [31:0] WbCount;
`endif

  int checks = 0;
  int errors = 0;

  cache_refill_ctrl #(.LINE_WORDS(4), .WORD_W(2)) dut (
    .CLK(CLK), .Reset(Reset), .Req(Req), .Addr(Addr), .h(h),
    .Replaced_Tag(Replaced_Tag), .Dirty(Dirty), .RepPtr(RepPtr),
    .TagValid(TagValid), .Stall(Stall), .MemReq(MemReq), .MemWE(MemWE),
    .MemAddr(MemAddr), .MemAck(MemAck), .WordIdx(WordIdx), .FillWE(FillWE),
`ifdef REFILL_PERF_EN
    .MissCount(MissCount), .WbCount(WbCount),
`endif
    .LineDone(LineDone)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic        rst, req, hit;
    logic [31:0] addr;
    logic [27:0] rtag;
    logic        dirty, ack;
    logic        stall, mreq, mwe;
    logic [31:0] maddr;
    logic        fillwe, tagv, done;
    logic [1:0]  widx;
    logic [7:0]  rptr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic rst, logic req, logic hit, logic [31:0] addr,
                              logic [27:0] rtag, logic dirty, logic ack, logic stall, logic mreq,
                              logic mwe, logic [31:0] maddr, logic fillwe, logic tagv, logic done,
                              logic [1:0] widx, logic [7:0] rptr);
    vec_t v;
    v.name = name; v.rst = rst; v.req = req; v.hit = hit; v.addr = addr; v.rtag = rtag;
    v.dirty = dirty; v.ack = ack; v.stall = stall; v.mreq = mreq; v.mwe = mwe; v.maddr = maddr;
    v.fillwe = fillwe; v.tagv = tagv; v.done = done; v.widx = widx; v.rptr = rptr;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, compare outputs mid-cycle, then advance past the next edge.
  task automatic apply(vec_t v);
    Reset = v.rst; Req = v.req; h = v.hit; Addr = v.addr;
    Replaced_Tag = v.rtag; Dirty = v.dirty; MemAck = v.ack;
    @(negedge CLK);
    chk({v.name, ".Stall"},    32'(Stall),    32'(v.stall));
    chk({v.name, ".MemReq"},   32'(MemReq),   32'(v.mreq));
    if (v.mreq) begin
      chk({v.name, ".MemWE"},   32'(MemWE),   32'(v.mwe));
      chk({v.name, ".MemAddr"}, MemAddr,      v.maddr);
    end
    chk({v.name, ".FillWE"},   32'(FillWE),   32'(v.fillwe));
    chk({v.name, ".TagValid"}, 32'(TagValid), 32'(v.tagv));
    chk({v.name, ".LineDone"}, 32'(LineDone), 32'(v.done));
    chk({v.name, ".WordIdx"},  32'(WordIdx),  32'(v.widx));
    chk({v.name, ".RepPtr"},   32'(RepPtr),   32'(v.rptr));
    $display("vec %-12s Stall=%0b MemReq=%0b MemWE=%0b MemAddr=%h WordIdx=%0d RepPtr=%0d TagValid=%0b",
             v.name, Stall, MemReq, MemWE, MemAddr, WordIdx, RepPtr, TagValid);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    vec_t v;

    // Vector table: hit/no-request in IDLE, clean miss, dirty miss (MemAck tied high).
    vecs.push_back(mk("hit_idle",   0,1,1,32'h0000_4440,28'h1111111,0,0, 0,0,0,32'h0,0,0,0,2'd0,8'd0));
    vecs.push_back(mk("noreq_idle", 0,0,0,32'h0000_4440,28'h1111111,1,0, 0,0,0,32'h0,0,0,0,2'd0,8'd0));
    vecs.push_back(mk("c_detect",   0,1,0,32'h0000_1230,28'h5555555,0,1, 1,0,0,32'h0,0,0,0,2'd0,8'd0));
    for (int w = 0; w < 4; w++)
      vecs.push_back(mk("c_fill", 0,1,0,32'h0000_1230,28'h5555555,0,1,
                        1,1,0,32'h0000_1230 + 32'(4*w),1,0,0,2'(w),8'd0));
    vecs.push_back(mk("c_commit",   0,1,0,32'h0000_1230,28'h5555555,0,1, 1,0,0,32'h0,0,1,1,2'd0,8'd0));
    vecs.push_back(mk("c_after",    0,1,1,32'h0000_1230,28'h5555555,0,1, 0,0,0,32'h0,0,0,0,2'd0,8'd1));
    vecs.push_back(mk("d_detect",   0,1,0,32'h0000_5670,28'hABCDEF0,1,1, 1,0,0,32'h0,0,0,0,2'd0,8'd1));
    for (int w = 0; w < 4; w++)
      vecs.push_back(mk("d_wb", 0,1,0,32'h0000_5670,28'hABCDEF0,1,1,
                        1,1,1,32'hABCD_EF00 + 32'(4*w),0,0,0,2'(w),8'd1));
    for (int w = 0; w < 4; w++)
      vecs.push_back(mk("d_fill", 0,1,0,32'h0000_5670,28'hABCDEF0,1,1,
                        1,1,0,32'h0000_5670 + 32'(4*w),1,0,0,2'(w),8'd1));
    vecs.push_back(mk("d_commit",   0,1,0,32'h0000_5670,28'hABCDEF0,1,1, 1,0,0,32'h0,0,1,1,2'd0,8'd1));
    vecs.push_back(mk("d_after",    0,1,1,32'h0000_5670,28'hABCDEF0,1,0, 0,0,0,32'h0,0,0,0,2'd0,8'd2));

    Reset = 1'b1; Req = 1'b0; h = 1'b0; Addr = '0; Replaced_Tag = '0; Dirty = 1'b0; MemAck = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

`ifdef REFILL_PERF_EN
    chk("perf_reset.MissCount", MissCount, 32'd0);
    chk("perf_reset.WbCount",   WbCount,   32'd0);
`endif

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

`ifdef REFILL_PERF_EN
    chk("perf.MissCount", MissCount, 32'd2);
    chk("perf.WbCount",   WbCount,   32'd1);
`endif

    // Slow memory: ack on every third cycle; Req drops after detect and the miss still completes.
    apply(mk("s_detect", 0,1,0,32'h0000_9AB0,28'h2222222,0,0, 1,0,0,32'h0,0,0,0,2'd0,8'd2));
    for (int w = 0; w < 4; w++)
      for (int d = 0; d < 3; d++)
        apply(mk("s_fill", 0,0,0,32'h0000_9AB0,28'h2222222,0,logic'(d == 2),
                 1,1,0,32'h0000_9AB0 + 32'(4*w),logic'(d == 2),0,0,2'(w),8'd2));
    apply(mk("s_commit", 0,0,0,32'h0000_9AB0,28'h2222222,0,0, 1,0,0,32'h0,0,1,1,2'd0,8'd2));
    apply(mk("s_after",  0,0,0,32'h0000_9AB0,28'h2222222,0,0, 0,0,0,32'h0,0,0,0,2'd0,8'd3));

    // Run 252 back-to-back clean misses (6 cycles each) to bring RepPtr to 255.
    Reset = 1'b0; Req = 1'b1; h = 1'b0; Dirty = 1'b0; MemAck = 1'b1; Addr = 32'h0000_7000;
    repeat (252 * 6) @(posedge CLK);
    #1;
    apply(mk("w_hit",    0,1,1,32'h0000_7000,28'h0,0,0, 0,0,0,32'h0,0,0,0,2'd0,8'd255));
    apply(mk("w_detect", 0,1,0,32'h0000_8880,28'h0,0,1, 1,0,0,32'h0,0,0,0,2'd0,8'd255));
    for (int w = 0; w < 4; w++)
      apply(mk("w_fill", 0,1,0,32'h0000_8880,28'h0,0,1,
               1,1,0,32'h0000_8880 + 32'(4*w),1,0,0,2'(w),8'd255));
    apply(mk("w_commit", 0,1,0,32'h0000_8880,28'h0,0,1, 1,0,0,32'h0,0,1,1,2'd0,8'd255));
    apply(mk("w_after",  0,1,1,32'h0000_8880,28'h0,0,0, 0,0,0,32'h0,0,0,0,2'd0,8'd0));

    // One more clean miss so the reset-abort below has a nonzero RepPtr to clear.
    Req = 1'b1; h = 1'b0; MemAck = 1'b1; Dirty = 1'b0;
    repeat (6) @(posedge CLK);
    #1;
    apply(mk("r_hit",    0,1,1,32'h0000_2220,28'h0,0,0, 0,0,0,32'h0,0,0,0,2'd0,8'd1));
    apply(mk("r_detect", 0,1,0,32'h0000_2220,28'h0,0,1, 1,0,0,32'h0,0,0,0,2'd0,8'd1));
    apply(mk("r_fill0",  0,1,0,32'h0000_2220,28'h0,0,1, 1,1,0,32'h0000_2220,1,0,0,2'd0,8'd1));
    apply(mk("r_fill1",  1,1,0,32'h0000_2220,28'h0,0,0, 1,1,0,32'h0000_2224,0,0,0,2'd1,8'd1));
    for (int i = 0; i < 3; i++)
      apply(mk("r_idle", 0,0,0,32'h0000_2220,28'h0,0,0, 0,0,0,32'h0,0,0,0,2'd0,8'd0));
`ifdef REFILL_PERF_EN
    chk("perf_abort.MissCount", MissCount, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
